// File: rtl/search_best_mv_tracker.sv
// Tracks the per-partition minimum SAD and its motion vector over a
// row-fast SR_COLS x SR_ROWS search window, with optional early exit.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin a search (IDLE only) / cancel (SEARCH, HOLD)
//   cfg_early_en/_thr     early-termination config, latched at start
//   sad_valid/sad_ready   SAD vector handshake, sad_in[p*SAD_W +: SAD_W]
//   search_*_count        candidate position expected on the next beat
//   busy                  high while in SEARCH or HOLD
//   res_valid/res_ready   result handshake
//   best_sad/col/row      per-partition minimum and its position
//   early_term            result ended by early termination
module search_best_mv_tracker #(
    parameter int NUM_PART = 4,
    parameter int SAD_W    = 16,
    parameter int SR_COLS  = 32,
    parameter int SR_ROWS  = 64,
    parameter int COL_W    = 5,
    parameter int ROW_W    = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      cfg_early_en,
    input  logic [SAD_W-1:0]          cfg_early_thr,
    input  logic                      sad_valid,
    output logic                      sad_ready,
    input  logic [NUM_PART*SAD_W-1:0] sad_in,
    output logic [COL_W-1:0]          search_column_count,
    output logic [ROW_W-1:0]          search_row_count,
    output logic                      busy,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [NUM_PART*SAD_W-1:0] best_sad,
    output logic [NUM_PART*COL_W-1:0] best_col,
    output logic [NUM_PART*ROW_W-1:0] best_row,
    output logic                      early_term
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SR_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SR_ROWS - 1);

    logic [1:0]                  state_q, state_d;
    logic [COL_W-1:0]            col_q, col_d, col_nxt;
    logic [ROW_W-1:0]            row_q, row_d, row_nxt;
    logic [NUM_PART*SAD_W-1:0]   best_sad_q, best_sad_d, upd_sad;
    logic [NUM_PART*COL_W-1:0]   best_col_q, best_col_d, upd_col;
    logic [NUM_PART*ROW_W-1:0]   best_row_q, best_row_d, upd_row;
    logic                        early_q, early_d;
    logic                        en_q, en_d;
    logic [SAD_W-1:0]            thr_q, thr_d;
    logic                        accept;
    logic                        last_cand;
    logic                        all_below;

    // abort wins over a beat offered in the same cycle
    assign accept    = (state_q == S_SEARCH) && sad_valid && !abort;
    assign last_cand = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // row-fast scan: row wraps first, then the column steps
    always_comb begin
        row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        col_nxt = col_q;
        if (row_q == ROW_LAST) begin
            col_nxt = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
    end

    // strict compare keeps the earlier candidate on ties; the early-exit
    // test looks at the minima after this beat's update
    always_comb begin
        upd_sad   = best_sad_q;
        upd_col   = best_col_q;
        upd_row   = best_row_q;
        all_below = 1'b1;
        for (int p = 0; p < NUM_PART; p++) begin
            if (sad_in[p*SAD_W +: SAD_W] < best_sad_q[p*SAD_W +: SAD_W]) begin
                upd_sad[p*SAD_W +: SAD_W] = sad_in[p*SAD_W +: SAD_W];
                upd_col[p*COL_W +: COL_W] = col_q;
                upd_row[p*ROW_W +: ROW_W] = row_q;
            end
            if (!(upd_sad[p*SAD_W +: SAD_W] < thr_q)) begin
                all_below = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        best_sad_d = best_sad_q;
        best_col_d = best_col_q;
        best_row_d = best_row_q;
        early_d    = early_q;
        en_d       = en_q;
        thr_d      = thr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    en_d       = cfg_early_en;
                    thr_d      = cfg_early_thr;
                    best_sad_d = '1;
                    best_col_d = '0;
                    best_row_d = '0;
                    col_d      = '0;
                    row_d      = '0;
                    early_d    = 1'b0;
                    state_d    = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    best_sad_d = upd_sad;
                    best_col_d = upd_col;
                    best_row_d = upd_row;
                    col_d      = col_nxt;
                    row_d      = row_nxt;
                    if (en_q && all_below) begin
                        early_d = 1'b1;
                        state_d = S_HOLD;
                    end else if (last_cand) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (abort || res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            best_sad_q <= '1;
            best_col_q <= '0;
            best_row_q <= '0;
            early_q    <= 1'b0;
            en_q       <= 1'b0;
            thr_q      <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            best_sad_q <= best_sad_d;
            best_col_q <= best_col_d;
            best_row_q <= best_row_d;
            early_q    <= early_d;
            en_q       <= en_d;
            thr_q      <= thr_d;
        end
    end

    assign sad_ready           = (state_q == S_SEARCH);
    assign busy                = (state_q != S_IDLE);
    assign res_valid           = (state_q == S_HOLD);
    assign search_column_count = col_q;
    assign search_row_count    = row_q;
    assign best_sad            = best_sad_q;
    assign best_col            = best_col_q;
    assign best_row            = best_row_q;
    assign early_term          = early_q;

endmodule
